comparator_bist: RTL
====================

Name: comparator_bist

Overview:
- Self-checking stimulus/response engine for the combinational magnitude comparator: the hardware counterpart of the comparator bench.
- Drives the comparator's a/b inputs through every operand pair and consumes its 3-bit c result.
- Checks each c against an internal golden model and reports pass/fail, error count and the first failing vector.
- Sits beside the comparator in bring-up/self-test builds; the comparator is the device under test (DUT).

Parameters:
- WIDTH, 2, operand width of a and b.
- SETTLE, 1, extra clock cycles each vector is held before c_in is sampled; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- a_out  output  WIDTH  operand a driven to DUT.
- b_out  output  WIDTH  operand b driven to DUT.
- c_in  input  3  DUT result: c[2]=a>b, c[1]=a==b, c[0]=a<b (one-hot).
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  high after a sweep with zero errors; held until the next start.
- err_count  output  2*WIDTH+1  number of mismatching vectors in the last or current sweep.
- fail_valid  output  1  at least one mismatch recorded in this sweep.
- fail_a  output  WIDTH  a of the first mismatching vector.
- fail_b  output  WIDTH  b of the first mismatching vector.

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; vector counter 0. Reset mid-sweep aborts immediately with no done pulse.
- State machine states: IDLE, HOLD, CHECK, FIN.
  - IDLE: on start=1, load vector 0 (a_out=0, b_out=0), clear err_count, fail_*, pass; set busy=1; go to HOLD with hold counter = SETTLE.
  - HOLD: if hold counter is 0, go to CHECK; else decrement. Each vector is presented for SETTLE+1 cycles; c_in is sampled at the edge that ends the window.
  - CHECK is the sampling edge, not an extra cycle:
    - Compute expected = {a>b, a==b, a<b} for the current a_out and b_out.
    - If c_in != expected (this includes any non-one-hot c_in), increment err_count.
    - If fail_valid is 0 at that point, latch fail_a/fail_b and set fail_valid.
    - If this is not the last vector, advance the counter, drive the next vector and return to HOLD.
    - If it is the last vector, go to FIN.
  - FIN, one cycle: done=1, busy=0, pass = (err_count==0); then go to IDLE.
- Sweep order: counter {a,b} increments from 0 to 2^(2*WIDTH)-1; a is the major field, b the minor field. For WIDTH=2 the order is (0,0),(0,1)…(3,3).
- Latency, WIDTH=2: with the start edge as edge 0, the last sample is at edge 16*(SETTLE+1). done is high in the following cycle. SETTLE=1 gives 32 cycles.
- start while busy, or in the FIN cycle, is ignored.
- start in IDLE after a completed sweep restarts and clears all results.
- err_count cannot overflow; its maximum is 2^(2*WIDTH).
- a_out and b_out hold the last vector after completion, until the next start.
- Vector boundary: the next vector changes on the same edge that samples the previous one, so c_in must never be sampled in the first cycle of a new vector.

Test Plan:
- Behavioural comparator model connected, SETTLE=1, start pulse -> 16 vectors in a>b major order; done pulses 32 cycles after the start edge; pass=1, err_count=0, fail_valid=0.
- c_in stuck at 3'b010 -> err_count=12, pass=0, fail_valid=1, fail_a=0, fail_b=1.
- c[2] and c[0] swapped in the DUT model -> err_count=12, first failure at fail_a=0, fail_b=1.
- c_in stuck at 3'b000 -> err_count=16, first failure at fail_a=0, fail_b=0.
- start re-pulsed mid-sweep -> ignored, with a single done at the original cycle. A following start clears the old err_count, and a clean model then gives pass=1.
- rst asserted at vector 7 -> all outputs 0 asynchronously and no done pulse. A later start runs a full 16-vector sweep from (0,0).

Source files
------------

// File: rtl/comparator_bist_if.sv
// Bus between the comparator BIST engine and its controller: sweep control,
// operand/result lines to the comparator under test, and the result registers.
interface comparator_bist_if #(
    parameter int WIDTH = 2
);
    logic               start;
    logic [WIDTH-1:0]   a_out;
    logic [WIDTH-1:0]   b_out;
    logic [2:0]         c_in;
    logic               busy;
    logic               done;
    logic               pass;
    logic [2*WIDTH:0]   err_count;
    logic               fail_valid;
    logic [WIDTH-1:0]   fail_a;
    logic [WIDTH-1:0]   fail_b;

    // Controller / environment side: requests sweeps and returns the comparator result.
    modport master (
        output start, c_in,
        input  a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b
    );

    // BIST engine side.
    modport slave (
        input  start, c_in,
        output a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b
    );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive stimulus/response self-test for a magnitude comparator: sweeps every
// {a,b} pair, checks c against a golden model, records error count and first failure.
module comparator_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    comparator_bist_if.slave bus
);
    localparam int VW = 2 * WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    logic [1:0]       state;
    logic [3:0]       hold_cnt;
    logic [VW-1:0]    vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic [VW:0]      err_count;
    logic             fail_valid;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       expected;
    logic             sample;
    logic             mismatch;
    logic [VW:0]      err_next;

    // a is the major field of the sweep counter, b the minor one.
    assign a        = vec[VW-1:WIDTH];
    assign b        = vec[WIDTH-1:0];
    assign expected = {a > b, a == b, a < b};

    // The check happens on the edge that closes a vector's hold window, not in a
    // separate cycle, so the next vector goes out on that same edge.
    assign sample   = (state == HOLD) && (hold_cnt == 4'd0);
    assign mismatch = sample && (bus.c_in != expected);
    assign err_next = err_count + (VW + 1)'(mismatch);

    // NOTE: all state below uses non-blocking assignments so every register
    // updates from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        hold_cnt   <= SETTLE_CNT;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end else begin
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_a     <= a;
                            fail_b     <= b;
                        end
                        if (vec != '1) begin
                            vec      <= vec + VW'(1);
                            hold_cnt <= SETTLE_CNT;
                        end else begin
                            // Last vector: the operands stay on the bus until the next start.
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_out      = a;
    assign bus.b_out      = b;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.pass       = pass;
    assign bus.err_count  = err_count;
    assign bus.fail_valid = fail_valid;
    assign bus.fail_a     = fail_a;
    assign bus.fail_b     = fail_b;
endmodule
